// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-port memory arbiter/sequencer.
package mem_arb_pkg;

  // Sequencer states: one access runs IDLE -> ACCESS -> (RMW_WR) -> DONE
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RMW_WR = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Port identifiers: port 0 is instruction fetch, port 1 is load/store
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  // Merges one byte lane: the enabled lane takes the new byte, otherwise
  // the byte captured from memory is kept.
  function automatic logic [7:0] byte_merge(input logic [7:0] oldByte,
                                            input logic [7:0] newByte,
                                            input logic       be);
    return be ? newByte : oldByte;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter: combinational grant, registered last-grant pointer.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant,
  output logic       o_port,
  output logic       o_valid
);

  logic r_last;
  logic w_winner;

  // Pick the winner: a lone requester wins, on contention the port that did not win last time
  always_comb begin
    w_winner = PORT_IF;
    if (i_req[0] && i_req[1]) begin
      w_winner = ~r_last;
    end else if (i_req[1]) begin
      w_winner = PORT_LS;
    end
    o_valid = i_en && (|i_req);
    o_port  = w_winner;
    o_grant = 2'b00;
    if (o_valid) begin
      o_grant = w_winner ? 2'b10 : 2'b01;
    end
  end

  // Remember the last granted port; reset points at port 1 so port 0 wins the first contest
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= PORT_LS;
    end else if (o_valid) begin
      r_last <= w_winner;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter and access sequencer for a single-port word memory.
// Sub-word stores become read-modify-write so the memory only sees whole words.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDRSIZE = 32,
  parameter int WORDSIZE = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic                    we0,
  input  logic [WORDSIZE/8-1:0]   be0,
  input  logic [ADDRSIZE-1:0]     addr0,
  input  logic [WORDSIZE-1:0]     wd0,
  input  logic                    req1,
  input  logic                    we1,
  input  logic [WORDSIZE/8-1:0]   be1,
  input  logic [ADDRSIZE-1:0]     addr1,
  input  logic [WORDSIZE-1:0]     wd1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    done0,
  output logic                    done1,
  output logic [WORDSIZE-1:0]     rdata,
  output logic                    busy,
  output logic                    mem_wren,
  output logic                    mem_rden,
  output logic [ADDRSIZE-1:0]     mem_addr,
  output logic [WORDSIZE-1:0]     mem_d,
  input  logic [WORDSIZE-1:0]     mem_q
);

  localparam int NBYTES = WORDSIZE / 8;

  state_t              r_state;
  logic                r_port;
  logic                r_we;
  logic [NBYTES-1:0]   r_be;
  logic [WORDSIZE-1:0] r_wd;
  logic                r_done0;
  logic                r_done1;
  logic [WORDSIZE-1:0] r_rdata;
  logic                r_busy;
  logic                r_memWren;
  logic                r_memRden;
  logic [ADDRSIZE-1:0] r_memAddr;
  logic [WORDSIZE-1:0] r_memD;

  logic                w_arbEn;
  logic [1:0]          w_grant;
  logic                w_gntPort;
  logic                w_gntValid;
  logic                w_selWe;
  logic [NBYTES-1:0]   w_selBe;
  logic [ADDRSIZE-1:0] w_selAddr;
  logic [WORDSIZE-1:0] w_selWd;
  logic [WORDSIZE-1:0] w_merged;

  // Grants happen only in IDLE and never while reset is held
  assign w_arbEn = (r_state == IDLE) && !rst;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_arbEn),
    .i_req   ({req1, req0}),
    .o_grant (w_grant),
    .o_port  (w_gntPort),
    .o_valid (w_gntValid)
  );

  // Route the winning port's request fields toward the latch registers
  always_comb begin
    w_selWe   = we0;
    w_selBe   = be0;
    w_selAddr = addr0;
    w_selWd   = wd0;
    if (w_gntPort == PORT_LS) begin
      w_selWe   = we1;
      w_selBe   = be1;
      w_selAddr = addr1;
      w_selWd   = wd1;
    end
  end

  // Combine the word read during ACCESS with the enabled bytes of the latched store data
  always_comb begin
    w_merged = '0;
    for (int i = 0; i < NBYTES; i++) begin
      w_merged[8*i +: 8] = byte_merge(mem_q[8*i +: 8], r_wd[8*i +: 8], r_be[i]);
    end
  end

  // Access sequencer; every memory-side and handshake output is a register
  // set on the transition into the state where it must be visible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_port    <= PORT_IF;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_wd      <= '0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_rdata   <= '0;
      r_busy    <= 1'b0;
      r_memWren <= 1'b0;
      r_memRden <= 1'b0;
      r_memAddr <= '0;
      r_memD    <= '0;
    end else begin
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_memWren <= 1'b0;
      r_memRden <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gntValid) begin
            r_port    <= w_gntPort;
            r_we      <= w_selWe;
            r_be      <= w_selBe;
            r_wd      <= w_selWd;
            r_memAddr <= w_selAddr;
            r_busy    <= 1'b1;
            r_state   <= ACCESS;
            if (!w_selWe) begin
              r_memRden <= 1'b1;
            end else if (&w_selBe) begin
              r_memWren <= 1'b1;
              r_memD    <= w_selWd;
            end else if (|w_selBe) begin
              r_memRden <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (r_we && (|r_be) && !(&r_be)) begin
            r_memD    <= w_merged;
            r_memWren <= 1'b1;
            r_state   <= RMW_WR;
          end else begin
            if (!r_we) begin
              r_rdata <= mem_q;
            end
            r_done0 <= (r_port == PORT_IF);
            r_done1 <= (r_port == PORT_LS);
            r_state <= DONE;
          end
        end
        RMW_WR: begin
          r_done0 <= (r_port == PORT_IF);
          r_done1 <= (r_port == PORT_LS);
          r_state <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gnt0     = w_grant[0];
  assign gnt1     = w_grant[1];
  assign done0    = r_done0;
  assign done1    = r_done1;
  assign rdata    = r_rdata;
  assign busy     = r_busy;
  assign mem_wren = r_memWren;
  assign mem_rden = r_memRden;
  assign mem_addr = r_memAddr;
  assign mem_d    = r_memD;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a small behavioural memory.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        req0;
  logic        we0;
  logic [3:0]  be0;
  logic [31:0] addr0;
  logic [31:0] wd0;
  logic        req1;
  logic        we1;
  logic [3:0]  be1;
  logic [31:0] addr1;
  logic [31:0] wd1;
  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic [31:0] rdata;
  logic        busy;
  logic        mem_wren;
  logic        mem_rden;
  logic [31:0] mem_addr;
  logic [31:0] mem_d;
  logic [31:0] mem_q;

  logic        memInit;
  logic [31:0] mem [0:15];

  int checkCount;
  int errorCount;

  mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req0),
    .we0      (we0),
    .be0      (be0),
    .addr0    (addr0),
    .wd0      (wd0),
    .req1     (req1),
    .we1      (we1),
    .be1      (be1),
    .addr1    (addr1),
    .wd1      (wd1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .done0    (done0),
    .done1    (done1),
    .rdata    (rdata),
    .busy     (busy),
    .mem_wren (mem_wren),
    .mem_rden (mem_rden),
    .mem_addr (mem_addr),
    .mem_d    (mem_d),
    .mem_q    (mem_q)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge, preload while memInit is high
  assign mem_q = (mem_addr < 32'd16) ? mem[mem_addr[3:0]] : 32'd0;

  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 16; i++) begin
        mem[i] <= 32'd0;
      end
      mem[3] <= 32'h11223344;
      mem[5] <= 32'hDEADBEEF;
    end else if (mem_wren && (mem_addr < 32'd16)) begin
      mem[mem_addr[3:0]] <= mem_d;
    end
  end

  // Compare one observed value with its expected value and count the outcome
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic waitCycle;
    @(posedge clk);
    #1;
  endtask

  // Raise a request on one port in IDLE and check that the grant appears in the same cycle
  task automatic applyStimulus(input logic port, input logic we, input logic [3:0] be,
                               input logic [31:0] addr, input logic [31:0] wd);
    if (port == 1'b0) begin
      we0 = we; be0 = be; addr0 = addr; wd0 = wd; req0 = 1'b1;
    end else begin
      we1 = we; be1 = be; addr1 = addr; wd1 = wd; req1 = 1'b1;
    end
    #1;
    checkOutput("gntAtT", {30'd0, gnt1, gnt0}, (port == 1'b1) ? 32'd2 : 32'd1);
  endtask

  task automatic dropRequests;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  // Safety net so the bench always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst = 1'b1; memInit = 1'b1;
    req0 = 1'b0; we0 = 1'b0; be0 = 4'h0; addr0 = 32'd0; wd0 = 32'd0;
    req1 = 1'b0; we1 = 1'b0; be1 = 4'h0; addr1 = 32'd0; wd1 = 32'd0;
    waitCycle;
    waitCycle;
    memInit = 1'b0;

    // Reset state
    checkOutput("rstGnt",   {30'd0, gnt1, gnt0}, 32'd0);
    checkOutput("rstDone",  {30'd0, done1, done0}, 32'd0);
    checkOutput("rstBusy",  {31'd0, busy}, 32'd0);
    checkOutput("rstStrb",  {30'd0, mem_wren, mem_rden}, 32'd0);
    checkOutput("rstRdata", rdata, 32'd0);
    checkOutput("rstAddr",  mem_addr, 32'd0);
    rst = 1'b0;
    #1;

    // Port 0 read of address 5
    applyStimulus(1'b0, 1'b0, 4'h0, 32'd5, 32'd0);
    waitCycle;
    dropRequests;
    checkOutput("rdStrbT1", {30'd0, mem_wren, mem_rden}, 32'd1);
    checkOutput("rdAddrT1", mem_addr, 32'd5);
    checkOutput("rdBusyT1", {31'd0, busy}, 32'd1);
    checkOutput("rdDoneT1", {30'd0, done1, done0}, 32'd0);
    waitCycle;
    checkOutput("rdDoneT2", {30'd0, done1, done0}, 32'd1);
    checkOutput("rdStrbT2", {30'd0, mem_wren, mem_rden}, 32'd0);
    checkOutput("rdData",   rdata, 32'hDEADBEEF);
    waitCycle;
    checkOutput("rdIdle",   {29'd0, busy, done1, done0}, 32'd0);

    // Both requesters held from reset: alternate 0,1,0,1 every three cycles
    rst = 1'b1;
    we0 = 1'b0; addr0 = 32'd5; we1 = 1'b0; addr1 = 32'd3;
    req0 = 1'b1; req1 = 1'b1;
    waitCycle;
    rst = 1'b0;
    #1;
    for (int c = 0; c < 12; c++) begin
      checkOutput("rrGnt", {30'd0, gnt1, gnt0},
                  (c % 3 != 0) ? 32'd0 : ((c % 6 == 0) ? 32'd1 : 32'd2));
      checkOutput("rrDone", {30'd0, done1, done0},
                  (c % 3 != 2) ? 32'd0 : ((c % 6 == 2) ? 32'd1 : 32'd2));
      waitCycle;
    end
    dropRequests;
    rst = 1'b1;
    waitCycle;
    rst = 1'b0;
    #1;

    // Partial write aborted by reset while in ACCESS
    applyStimulus(1'b1, 1'b1, 4'b0010, 32'd3, 32'h0000AB00);
    waitCycle;
    dropRequests;
    checkOutput("abRden", {30'd0, mem_wren, mem_rden}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abOuts", {27'd0, busy, gnt1, gnt0, done1, done0}, 32'd0);
    checkOutput("abStrb", {30'd0, mem_wren, mem_rden}, 32'd0);
    checkOutput("abMemD", mem_d, 32'd0);
    checkOutput("abAddr", mem_addr, 32'd0);
    waitCycle;
    checkOutput("abMem3", mem[3], 32'h11223344);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      waitCycle;
      checkOutput("abNoDone", {29'd0, mem_wren, done1, done0}, 32'd0);
    end

    // Partial write: byte 1 of address 3; fields changed after the grant are ignored
    applyStimulus(1'b1, 1'b1, 4'b0010, 32'd3, 32'h0000AB00);
    waitCycle;
    dropRequests;
    wd1 = 32'hFFFFFFFF; be1 = 4'hF;
    checkOutput("pwStrbT1", {30'd0, mem_wren, mem_rden}, 32'd1);
    checkOutput("pwAddrT1", mem_addr, 32'd3);
    waitCycle;
    checkOutput("pwStrbT2", {30'd0, mem_wren, mem_rden}, 32'd2);
    checkOutput("pwMemD",   mem_d, 32'h1122AB44);
    checkOutput("pwDoneT2", {30'd0, done1, done0}, 32'd0);
    waitCycle;
    checkOutput("pwDoneT3", {30'd0, done1, done0}, 32'd2);
    checkOutput("pwStrbT3", {30'd0, mem_wren, mem_rden}, 32'd0);
    checkOutput("pwMem3",   mem[3], 32'h1122AB44);
    checkOutput("pwRdata",  rdata, 32'd0);
    waitCycle;
    checkOutput("pwIdle",   {29'd0, busy, done1, done0}, 32'd0);

    // Full-word write on port 1 then read back on port 0
    applyStimulus(1'b1, 1'b1, 4'hF, 32'd8, 32'h12345678);
    waitCycle;
    dropRequests;
    checkOutput("fwStrbT1", {30'd0, mem_wren, mem_rden}, 32'd2);
    checkOutput("fwMemD",   mem_d, 32'h12345678);
    checkOutput("fwAddrT1", mem_addr, 32'd8);
    waitCycle;
    checkOutput("fwDoneT2", {30'd0, done1, done0}, 32'd2);
    checkOutput("fwStrbT2", {30'd0, mem_wren, mem_rden}, 32'd0);
    waitCycle;
    applyStimulus(1'b0, 1'b0, 4'h0, 32'd8, 32'd0);
    waitCycle;
    dropRequests;
    waitCycle;
    checkOutput("fwRdDone", {30'd0, done1, done0}, 32'd1);
    checkOutput("fwRdData", rdata, 32'h12345678);
    waitCycle;

    // Write with no byte enables completes as a no-op
    applyStimulus(1'b0, 1'b1, 4'h0, 32'd8, 32'hFFFFFFFF);
    waitCycle;
    dropRequests;
    checkOutput("nwStrbT1", {30'd0, mem_wren, mem_rden}, 32'd0);
    checkOutput("nwBusyT1", {31'd0, busy}, 32'd1);
    waitCycle;
    checkOutput("nwDoneT2", {30'd0, done1, done0}, 32'd1);
    checkOutput("nwStrbT2", {30'd0, mem_wren, mem_rden}, 32'd0);
    waitCycle;
    checkOutput("nwMem8",   mem[8], 32'h12345678);
    checkOutput("nwIdle",   {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
